// File: rtl/uart_program_dumper_if.sv
// rtl/uart_program_dumper_if.sv - synchronous-read memory port used by the program dumper
interface uart_program_dumper_if;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;

  modport master (output mem_addr, input mem_rdata);
  modport slave (input mem_addr, output mem_rdata);
endinterface

// File: rtl/uart_program_dumper.sv
// rtl/uart_program_dumper.sv - reads a block of 16-bit words and sends count + words over an 8N1 UART line
module uart_program_dumper #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD = 9600
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         start,
  input  logic [15:0]                  start_addr,
  input  logic [15:0]                  word_count,
  uart_program_dumper_if.master        mem,
  output logic                         tx,
  output logic                         busy,
  output logic                         done
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int CW = $clog2(BAUD_DIV);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {IDLE, CNT_L, CNT_H, FETCH, LATCH, W_L, W_H, FINISH} state_t;

  tx_state_t       tx_state, tx_state_n;
  logic [CW-1:0]   baud_cnt, baud_cnt_n;
  logic [2:0]      bit_idx, bit_idx_n;
  logic [7:0]      shreg, shreg_n;
  logic            load;
  logic [7:0]      load_byte;
  logic            eng_idle;
  logic            bit_end;

  state_t          state, state_n;
  logic [15:0]     addr, addr_n;
  logic [15:0]     cnt, cnt_n;
  logic [15:0]     remaining, remaining_n;
  logic [15:0]     word, word_n;
  logic [15:0]     maddr_q, maddr_n;

  assign eng_idle = (tx_state == TX_IDLE);
  assign bit_end  = (baud_cnt == CW'(BAUD_DIV - 1));

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      tx_state <= TX_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      tx_state <= tx_state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      shreg    <= shreg_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    baud_cnt_n = baud_cnt;
    bit_idx_n  = bit_idx;
    shreg_n    = shreg;
    if (tx_state != TX_IDLE) baud_cnt_n = bit_end ? '0 : baud_cnt + 1'b1;
    case (tx_state)
      TX_IDLE: if (load) begin
        tx_state_n = TX_START;
        baud_cnt_n = '0;
        bit_idx_n  = '0;
        shreg_n    = load_byte;
      end
      TX_START: if (bit_end) tx_state_n = TX_DATA;
      TX_DATA: if (bit_end) begin
        shreg_n   = {1'b0, shreg[7:1]};
        bit_idx_n = bit_idx + 3'd1;
        if (bit_idx == 3'd7) tx_state_n = TX_STOP;
      end
      TX_STOP: if (bit_end) tx_state_n = TX_IDLE;
      default: tx_state_n = TX_IDLE;
    endcase
  end

  always_comb begin
    case (tx_state)
      TX_START: tx = 1'b0;
      TX_DATA:  tx = shreg[0];
      default:  tx = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state     <= IDLE;
      addr      <= '0;
      cnt       <= '0;
      remaining <= '0;
      word      <= '0;
      maddr_q   <= '0;
    end else begin
      state     <= state_n;
      addr      <= addr_n;
      cnt       <= cnt_n;
      remaining <= remaining_n;
      word      <= word_n;
      maddr_q   <= maddr_n;
    end
  end

  // FETCH waits for the line to go idle so the 3-cycle pre-word gap is fixed.
  always_comb begin
    state_n     = state;
    addr_n      = addr;
    cnt_n       = cnt;
    remaining_n = remaining;
    word_n      = word;
    maddr_n     = maddr_q;
    load        = 1'b0;
    load_byte   = 8'h00;
    done        = 1'b0;
    case (state)
      IDLE: if (start) begin
        addr_n      = start_addr;
        cnt_n       = word_count;
        remaining_n = word_count;
        state_n     = CNT_L;
      end
      CNT_L: if (eng_idle) begin
        load      = 1'b1;
        load_byte = cnt[7:0];
        state_n   = CNT_H;
      end
      CNT_H: if (eng_idle) begin
        load      = 1'b1;
        load_byte = cnt[15:8];
        state_n   = (cnt == 16'd0) ? FINISH : FETCH;
      end
      FETCH: if (eng_idle) begin
        maddr_n = addr;
        state_n = LATCH;
      end
      LATCH: begin
        word_n  = mem.mem_rdata;
        state_n = W_L;
      end
      W_L: if (eng_idle) begin
        load      = 1'b1;
        load_byte = word[7:0];
        state_n   = W_H;
      end
      W_H: if (eng_idle) begin
        load        = 1'b1;
        load_byte   = word[15:8];
        remaining_n = remaining - 16'd1;
        addr_n      = addr + 16'd1;
        state_n     = (remaining == 16'd1) ? FINISH : FETCH;
      end
      FINISH: if (eng_idle) begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE) && !done;
  assign mem.mem_addr = (state == FETCH) ? addr : maddr_q;

endmodule

// File: tb/tb_uart_program_dumper.sv
// tb/tb_uart_program_dumper.sv - scoreboard bench: UART line decoder and done monitor against a byte-stream model
module tb_uart_program_dumper;
  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD = 100_000;
  localparam int D = CLK_FREQ / BAUD;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        start = 1'b0;
  logic [15:0] start_addr = '0;
  logic [15:0] word_count = '0;
  logic        tx, busy, done;

  uart_program_dumper_if mif();

  uart_program_dumper #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .start_addr(start_addr),
    .word_count(word_count), .mem(mif.master), .tx(tx), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  logic [15:0] mem_arr [0:65535];
  always @(posedge CLK) mif.mem_rdata <= mem_arr[mif.mem_addr];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int acc = 0;
  int done_cnt = 0;
  logic [7:0]  exp_q[$];
  int          gap_q[$];
  int          dur_q[$];
  logic [15:0] addr_log[$];
  logic [15:0] last_addr = '0;

  always @(posedge CLK) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  always @(negedge CLK) begin
    if (mif.mem_addr !== last_addr) begin
      addr_log.push_back(mif.mem_addr);
      last_addr = mif.mem_addr;
    end
  end

  always @(negedge CLK) begin
    if (RESET && done) begin
      done_cnt++;
      check("done_expected", dur_q.size() != 0, 1);
      if (dur_q.size() != 0) check("duration", cyc - acc, dur_q.pop_front());
    end
  end

  // Line decoder: every bit must hold for exactly D samples.
  bit       dec_active = 0;
  bit       gap_valid = 0;
  bit       stable;
  int       fc;
  int       gap_cnt = 0;
  logic [9:0] bitv;
  always @(negedge CLK) begin
    if (!RESET) begin
      dec_active = 0;
      gap_valid = 0;
    end else begin
      if (!dec_active && tx === 1'b0) begin
        dec_active = 1;
        fc = 0;
        stable = 1;
        if (gap_valid) begin
          check("gap_expected", gap_q.size() != 0, 1);
          if (gap_q.size() != 0) check("gap", gap_cnt, gap_q.pop_front());
        end
      end
      if (dec_active) begin
        if (fc % D == 0) bitv[fc / D] = tx;
        else if (tx !== bitv[fc / D]) stable = 0;
        if (fc == 10 * D - 1) begin
          dec_active = 0;
          check("frame_format", {stable, bitv[0], bitv[9]}, 3'b101);
          check("byte_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check("byte", bitv[8:1], exp_q.pop_front());
          gap_cnt = 0;
          gap_valid = 1;
        end else fc++;
      end else gap_cnt++;
      if (done) gap_valid = 0;
    end
  end

  task automatic model_push(input logic [15:0] sa, input logic [15:0] n);
    logic [15:0] w;
    exp_q.push_back(n[7:0]);
    exp_q.push_back(n[15:8]);
    gap_q.push_back(1);
    if (n != 0) gap_q.push_back(3);
    for (int i = 0; i < int'(n); i++) begin
      w = mem_arr[sa + 16'(i)];
      exp_q.push_back(w[7:0]);
      exp_q.push_back(w[15:8]);
      gap_q.push_back(1);
      if (i < int'(n) - 1) gap_q.push_back(3);
    end
    dur_q.push_back(2 + 20 * D + int'(n) * (4 + 20 * D));
  endtask

  task automatic run_dump(input logic [15:0] sa, input logic [15:0] n, input bit poke);
    logic [15:0] prev;
    logic [15:0] exp_log[$];
    int  bound, t, dc0;
    bit  seen, busy_bad;
    prev = last_addr;
    addr_log.delete();
    dc0 = done_cnt;
    model_push(sa, n);
    for (int i = 0; i < int'(n); i++)
      if (!(i == 0 && sa == prev)) exp_log.push_back(sa + 16'(i));
    @(negedge CLK);
    start_addr = sa;
    word_count = n;
    start = 1'b1;
    acc = cyc + 1;
    bound = 2 + 20 * D + int'(n) * (4 + 20 * D) + 50;
    seen = 0;
    busy_bad = 0;
    t = 0;
    while (t < bound && !seen) begin
      @(negedge CLK);
      t++;
      start = 1'b0;
      start_addr = 16'($urandom);
      word_count = 16'($urandom);
      if (poke && (t == 40 || t == 41)) begin
        start = 1'b1;
        word_count = n + 16'd5;
      end
      if (done) seen = 1;
      else if (!busy) busy_bad = 1;
    end
    start = 1'b0;
    check("done_seen", seen, 1);
    check("busy_throughout", busy_bad, 0);
    repeat (D * 3) @(negedge CLK);
    check("single_done", done_cnt - dc0, 1);
    check("bytes_left", exp_q.size(), 0);
    check("gaps_left", gap_q.size(), 0);
    check("addr_log_len", addr_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < addr_log.size(); i++)
      check("mem_addr_seq", addr_log[i], exp_log[i]);
  endtask

  task automatic reset_mid_dump();
    int dc0;
    model_push(16'h0040, 16'd4);
    dc0 = done_cnt;
    @(negedge CLK);
    start_addr = 16'h0040;
    word_count = 16'd4;
    start = 1'b1;
    acc = cyc + 1;
    @(negedge CLK);
    start = 1'b0;
    while (cyc < acc + 23 * D + 5) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    check("rst_mid_tx", tx, 1);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_mem_addr", mif.mem_addr, 0);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    exp_q.delete();
    gap_q.delete();
    dur_q.delete();
    repeat (5) @(negedge CLK);
    check("rst_mid_no_done", done_cnt - dc0, 0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem_arr[i] = 16'($urandom);
    mem_arr[16'h0010] = 16'h1234;
    mem_arr[16'h0011] = 16'hABCD;
    mem_arr[16'h0012] = 16'h00FF;
    mem_arr[16'h0200] = 16'h00A5;
    repeat (3) @(negedge CLK);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_addr", mif.mem_addr, 0);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    addr_log.delete();

    run_dump(16'h1234, 16'd0, 0);
    run_dump(16'h0010, 16'd3, 0);
    run_dump(16'h0200, 16'd1, 0);
    run_dump(16'hFFFE, 16'd3, 0);
    run_dump(16'h0100, 16'd2, 1);
    reset_mid_dump();
    run_dump(16'h0300, 16'd2, 0);
    for (int k = 0; k < 6; k++)
      run_dump(16'($urandom), 16'($urandom_range(0, 3)), k[0]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
